// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: sequential fetch, stall hold,
// buffered branch redirect, flush redirect and target alignment checking.
module pc_gen #(
    parameter int unsigned                 ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]       RESET_VECTOR = '0,
    parameter int unsigned                 INC_LOG2     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  ce,
    output logic                  branch_pending,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(1) << INC_LOG2;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = INC - ADDR_WIDTH'(1);

    // Source of the next pc, in decreasing priority.
    typedef enum logic [2:0] {
        SelReset,
        SelFlush,
        SelHold,
        SelBranch,
        SelPend,
        SelSeq
    } sel_e;

    sel_e                  sel;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ce_q;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
    logic                  addr_err_q, addr_err_d;
    logic [ADDR_WIDTH-1:0] raw_target;
    logic                  redirect;

    always_comb begin
        sel = SelSeq;
        if (!ce_q) begin
            sel = SelReset;
        end else if (flush) begin
            sel = SelFlush;
        end else if (stall) begin
            sel = SelHold;
        end else if (branch_flag) begin
            sel = SelBranch;
        end else if (pend_q) begin
            sel = SelPend;
        end
    end

    always_comb begin
        pc_d          = pc_q + INC;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        raw_target    = '0;
        redirect      = 1'b0;
        unique case (sel)
            SelReset: begin
                pc_d   = RESET_VECTOR;
                pend_d = 1'b0;
            end
            SelFlush: begin
                raw_target = flush_pc;
                redirect   = 1'b1;
                pend_d     = 1'b0;
            end
            SelHold: begin
                pc_d = pc_q;
                // Capture without checking; alignment is judged when applied.
                if (branch_flag) begin
                    pend_d        = 1'b1;
                    pend_target_d = branch_target;
                end
            end
            SelBranch: begin
                raw_target = branch_target;
                redirect   = 1'b1;
                pend_d     = 1'b0;
            end
            SelPend: begin
                raw_target = pend_target_q;
                redirect   = 1'b1;
                pend_d     = 1'b0;
            end
            SelSeq: begin
                pc_d = pc_q + INC;
            end
            default: begin
                pc_d = pc_q + INC;
            end
        endcase
        if (redirect) begin
            pc_d = raw_target & ~LOW_MASK;
        end
        addr_err_d = (INC_LOG2 != 0) && redirect && ((raw_target & LOW_MASK) != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ce_q          <= 1'b0;
            pc_q          <= RESET_VECTOR;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
            addr_err_q    <= 1'b0;
        end else begin
            ce_q          <= 1'b1;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc             = pc_q;
    assign ce             = ce_q;
    assign branch_pending = pend_q;
    assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected register state per edge,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pc_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
    logic        ce, branch_pending, addr_err;

    logic        reset2 = 1'b0;
    logic [7:0]  pc2;
    logic        ce2, bp2, ae2;

    typedef struct {
        bit          w;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        err;
        int          step;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   step = 0;

    always #5 clock = ~clock;

    pc_gen dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .pc             (pc),
        .ce             (ce),
        .branch_pending (branch_pending),
        .addr_err       (addr_err)
    );

    pc_gen #(
        .ADDR_WIDTH   (8),
        .RESET_VECTOR (8'hF8),
        .INC_LOG2     (2)
    ) dut_wrap (
        .clock          (clock),
        .reset          (reset2),
        .stall          (1'b0),
        .flush          (1'b0),
        .flush_pc       (8'h00),
        .branch_flag    (1'b0),
        .branch_target  (8'h00),
        .pc             (pc2),
        .ce             (ce2),
        .branch_pending (bp2),
        .addr_err       (ae2)
    );

    // Monitor: one expected entry per clock edge, checked half a cycle later.
    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [31:0] a_pc;
            logic        a_ce, a_pend, a_err;
            e = q.pop_front();
            if (e.w) begin
                a_pc = {24'h0, pc2};
                a_ce = ce2; a_pend = bp2; a_err = ae2;
            end else begin
                a_pc = pc;
                a_ce = ce; a_pend = branch_pending; a_err = addr_err;
            end
            total++;
            if (a_pc !== e.pc || a_ce !== e.ce || a_pend !== e.pend || a_err !== e.err) begin
                bad++;
                $display("FAIL step%0d dut%0d: got pc=%h ce=%b pend=%b err=%b, want pc=%h ce=%b pend=%b err=%b",
                         e.step, e.w, a_pc, a_ce, a_pend, a_err, e.pc, e.ce, e.pend, e.err);
            end
        end
    end

    task automatic push(input bit w, input logic [31:0] epc, input logic ece,
                        input logic epend, input logic eerr);
        exp_t e;
        e.w = w; e.pc = epc; e.ce = ece; e.pend = epend; e.err = eerr; e.step = step;
        q.push_back(e);
        step++;
    endtask

    // Drive inputs for one edge of the main DUT and record its expected state after it.
    task automatic cyc(input logic rst, input logic st, input logic fl, input logic [31:0] fpc,
                       input logic bf, input logic [31:0] bt,
                       input logic [31:0] epc, input logic ece, input logic epend,
                       input logic eerr);
        reset = rst; stall = st; flush = fl; flush_pc = fpc;
        branch_flag = bf; branch_target = bt;
        @(posedge clock);
        #1;
        push(1'b0, epc, ece, epend, eerr);
    endtask

    task automatic run(input logic [31:0] epc, input logic eerr);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 1'b1, 1'b0, eerr);
    endtask

    task automatic wcyc(input logic rst, input logic [31:0] epc, input logic ece);
        reset2 = rst;
        @(posedge clock);
        #1;
        push(1'b1, epc, ece, 1'b0, 1'b0);
    endtask

    initial begin
        // Wrap in an 8-bit instance
        wcyc(1'b0, 32'hF8, 1'b0);
        wcyc(1'b1, 32'hF8, 1'b1);
        wcyc(1'b1, 32'hFC, 1'b1);
        wcyc(1'b1, 32'h00, 1'b1);
        wcyc(1'b1, 32'h04, 1'b1);
        wcyc(1'b1, 32'h08, 1'b1);

        // Reset release
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        run(32'h0, 1'b0);
        run(32'h4, 1'b0);
        run(32'h8, 1'b0);
        run(32'hC, 1'b0);
        run(32'h10, 1'b0);

        // Stall with branch captured in stall cycle 2
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0, 0,        32'h10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h200,  32'h10, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b0, 0,        32'h10, 1'b1, 1'b1, 1'b0);
        run(32'h200, 1'b0);
        run(32'h204, 1'b0);

        // Last captured branch during a stall wins
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h300,  32'h204, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h340,  32'h204, 1'b1, 1'b1, 1'b0);
        run(32'h340, 1'b0);
        run(32'h344, 1'b0);

        // Flush beats stall, live branch and pending branch
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h500,         32'h344, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h180, 1'b1, 32'h400,   32'h180, 1'b1, 1'b0, 1'b0);
        run(32'h184, 1'b0);
        run(32'h188, 1'b0);

        // Live branch beats stale pending
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h600,  32'h188, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h700,  32'h700, 1'b1, 1'b0, 1'b0);
        run(32'h704, 1'b0);

        // Misaligned redirects: branch, flush, and pending applied later
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h1006,        32'h1004, 1'b1, 1'b0, 1'b1);
        run(32'h1008, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h2003, 1'b0, 0,        32'h2000, 1'b1, 1'b0, 1'b1);
        run(32'h2004, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h3001,        32'h2004, 1'b1, 1'b1, 1'b0);
        run(32'h3000, 1'b1);
        run(32'h3004, 1'b0);

        // Reset mid-pending; branch on the release edge is ignored while ce is low
        cyc(1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h800,  32'h3004, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 0,        32'h0,    1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h900,  32'h0,    1'b1, 1'b0, 1'b0);
        run(32'h4, 1'b0);
        run(32'h8, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
